// File: rtl/soc_bus_pkg.sv
// Shared types and default address map for the SoC shared-bus interconnect.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_ERR  = 2'd3
  } bus_state_t;

  localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

  // Default map: 256 MiB regions selected by the top address nibble.
  localparam logic [31:0] ROM_BASE    = 32'h0000_0000;
  localparam logic [31:0] RAM_BASE    = 32'h1000_0000;
  localparam logic [31:0] PERIPH_BASE = 32'h2000_0000;
  localparam logic [31:0] REGION_MASK = 32'hF000_0000;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/soc_bus_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr (wrapping) gets a one-hot grant.
module soc_bus_rr_arb #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!gnt_any && req[(32'(ptr) + i) % N]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'((32'(ptr) + i) % N);
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/soc_bus_xbar.sv
// Shared-bus interconnect: NUM_M masters, NUM_S address-decoded slaves, one transaction in flight.
module soc_bus_xbar
  import soc_bus_pkg::*;
#(
  parameter int unsigned          NUM_M   = 2,
  parameter int unsigned          NUM_S   = 3,
  parameter int unsigned          AW      = 32,
  parameter int unsigned          DW      = 32,
  parameter logic [NUM_S*AW-1:0]  S_BASE  = {PERIPH_BASE, RAM_BASE, ROM_BASE},
  parameter logic [NUM_S*AW-1:0]  S_MASK  = {REGION_MASK, REGION_MASK, REGION_MASK},
  parameter int unsigned          TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_M-1:0]        m_req_valid,
  output logic [NUM_M-1:0]        m_req_ready,
  input  logic [NUM_M*AW-1:0]     m_req_addr,
  input  logic [NUM_M-1:0]        m_req_we,
  input  logic [NUM_M*DW-1:0]     m_req_wdata,
  input  logic [NUM_M*DW/8-1:0]   m_req_be,
  output logic [NUM_M-1:0]        m_rsp_valid,
  output logic [DW-1:0]           m_rsp_rdata,
  output logic                    m_rsp_err,
  output logic [NUM_S-1:0]        s_req_valid,
  input  logic [NUM_S-1:0]        s_req_ready,
  output logic [AW-1:0]           s_req_addr,
  output logic                    s_req_we,
  output logic [DW-1:0]           s_req_wdata,
  output logic [DW/8-1:0]         s_req_be,
  input  logic [NUM_S-1:0]        s_rsp_valid,
  input  logic [NUM_S*DW-1:0]     s_rsp_rdata
);

  localparam int unsigned BW  = DW / 8;
  localparam int unsigned MIW = idx_width(NUM_M);
  localparam int unsigned SIW = idx_width(NUM_S);
  localparam int unsigned CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  bus_state_t     state;
  logic [MIW-1:0] ptr;
  logic [MIW-1:0] gnt_q;
  logic [SIW-1:0] hit_q;
  logic [CW-1:0]  cnt;

  logic [NUM_M-1:0] gnt_oh;
  logic [MIW-1:0]   gnt_idx;
  logic             gnt_any;
  logic [AW-1:0]    sel_addr;
  logic             dec_hit;
  logic [SIW-1:0]   dec_idx;
  logic             tmo;

  soc_bus_rr_arb #(
    .N  (NUM_M),
    .IW (MIW)
  ) u_arb (
    .req     (m_req_valid),
    .ptr     (ptr),
    .gnt     (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Acceptance is same-cycle in IDLE; held low while reset is asserted.
  assign m_req_ready = (state == ST_IDLE && !rst) ? gnt_oh : '0;

  assign tmo = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT));

  // Address decode of the granted master; lowest slave index wins on overlap.
  always_comb begin
    sel_addr = m_req_addr[int'(gnt_idx)*AW +: AW];
    dec_hit  = 1'b0;
    dec_idx  = '0;
    for (int i = int'(NUM_S) - 1; i >= 0; i--) begin
      if ((sel_addr & S_MASK[i*AW +: AW]) == S_BASE[i*AW +: AW]) begin
        dec_hit = 1'b1;
        dec_idx = SIW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      gnt_q       <= '0;
      hit_q       <= '0;
      cnt         <= '0;
      m_rsp_valid <= '0;
      m_rsp_rdata <= '0;
      m_rsp_err   <= 1'b0;
      s_req_valid <= '0;
      s_req_addr  <= '0;
      s_req_we    <= 1'b0;
      s_req_wdata <= '0;
      s_req_be    <= '0;
    end else begin
      m_rsp_valid <= '0;
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            ptr         <= (gnt_idx == MIW'(NUM_M - 1)) ? '0 : gnt_idx + MIW'(1);
            gnt_q       <= gnt_idx;
            hit_q       <= dec_idx;
            cnt         <= '0;
            s_req_addr  <= sel_addr;
            s_req_we    <= m_req_we[gnt_idx];
            s_req_wdata <= m_req_wdata[int'(gnt_idx)*DW +: DW];
            s_req_be    <= m_req_be[int'(gnt_idx)*BW +: BW];
            if (dec_hit) begin
              s_req_valid <= NUM_S'(1) << dec_idx;
              state       <= ST_REQ;
            end else begin
              state <= ST_ERR;
            end
          end
        end
        ST_REQ: begin
          if (s_req_ready[hit_q]) begin
            s_req_valid <= '0;
            cnt         <= cnt + CW'(1);
            state       <= ST_RSP;
          end else if (tmo) begin
            s_req_valid <= '0;
            state       <= ST_ERR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RSP: begin
          // Only the addressed slave can complete; stray responses are dropped.
          if (s_rsp_valid[hit_q]) begin
            m_rsp_valid <= NUM_M'(1) << gnt_q;
            m_rsp_rdata <= s_rsp_rdata[int'(hit_q)*DW +: DW];
            m_rsp_err   <= 1'b0;
            state       <= ST_IDLE;
          end else if (tmo) begin
            state <= ST_ERR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_ERR: begin
          m_rsp_valid <= NUM_M'(1) << gnt_q;
          m_rsp_rdata <= DW'(BUS_ERR_DATA);
          m_rsp_err   <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_bus_xbar.sv
// Directed bench for soc_bus_xbar: behavioural slaves plus a response scoreboard.
module tb_soc_bus_xbar;

  typedef struct packed {
    logic [1:0]  m;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_req_valid, m_req_ready, m_req_we, m_rsp_valid;
  logic [63:0] m_req_addr, m_req_wdata;
  logic [7:0]  m_req_be;
  logic [31:0] m_rsp_rdata;
  logic        m_rsp_err;
  logic [2:0]  s_req_valid, s_req_ready, s_rsp_valid;
  logic [31:0] s_req_addr, s_req_wdata;
  logic        s_req_we;
  logic [3:0]  s_req_be;
  logic [95:0] s_rsp_rdata;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [1:0] gnt_log[$];
  int   rdy_dly[3];
  bit   mute[3];
  int   wcnt[3];

  always #5 clk = ~clk;

  soc_bus_xbar #(.TIMEOUT(8)) dut (
    .clk (clk), .rst (rst),
    .m_req_valid (m_req_valid), .m_req_ready (m_req_ready),
    .m_req_addr (m_req_addr), .m_req_we (m_req_we),
    .m_req_wdata (m_req_wdata), .m_req_be (m_req_be),
    .m_rsp_valid (m_rsp_valid), .m_rsp_rdata (m_rsp_rdata), .m_rsp_err (m_rsp_err),
    .s_req_valid (s_req_valid), .s_req_ready (s_req_ready),
    .s_req_addr (s_req_addr), .s_req_we (s_req_we),
    .s_req_wdata (s_req_wdata), .s_req_be (s_req_be),
    .s_rsp_valid (s_rsp_valid), .s_rsp_rdata (s_rsp_rdata)
  );

  // Slave model: ready after rdy_dly waiting cycles, responds addr+3 the cycle after accept.
  always_comb begin
    s_req_ready = '0;
    for (int i = 0; i < 3; i++)
      s_req_ready[i] = s_req_valid[i] && (wcnt[i] >= rdy_dly[i]);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) wcnt[i] <= 0;
      s_rsp_valid <= '0;
      s_rsp_rdata <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        s_rsp_valid[i] <= 1'b0;
        wcnt[i] <= (s_req_valid[i] && !s_req_ready[i]) ? wcnt[i] + 1 : 0;
        if (s_req_valid[i] && s_req_ready[i] && !mute[i]) begin
          s_rsp_valid[i] <= 1'b1;
          s_rsp_rdata[i*32 +: 32] <= s_req_addr + 32'd3;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every response is matched in order against the expected queue.
  always @(negedge clk) begin
    if (!rst && m_rsp_valid != 2'b00) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(m_rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_master", 32'(m_rsp_valid), 32'(e.m));
        chk("rsp_rdata", m_rsp_rdata, e.rdata);
        chk("rsp_err", 32'(m_rsp_err), 32'(e.err));
      end
    end
  end

  // Single-master request; returns at the first falling edge after acceptance.
  task automatic do_req(input int m, input logic [31:0] a, input logic we,
                        input logic [31:0] wd, input logic [3:0] be);
    bit ok = 1'b0;
    int n = 0;
    @(negedge clk);
    m_req_valid[m] = 1'b1;
    m_req_addr[m*32 +: 32] = a;
    m_req_we[m] = we;
    m_req_wdata[m*32 +: 32] = wd;
    m_req_be[m*4 +: 4] = be;
    while (!ok && n < 100) begin
      #1;
      if (m_req_ready[m]) ok = 1'b1;
      @(negedge clk);
      n++;
    end
    m_req_valid[m] = 1'b0;
    chk("req_accepted", 32'(ok), 32'd1);
  endtask

  // Counts falling edges to the response; also tracks s_req_valid cycles and field stability.
  task automatic wait_rsp(output int lat, output int vcyc, output int bad,
                          input logic [31:0] ea, input logic ewe,
                          input logic [31:0] ewd, input logic [3:0] ebe);
    lat = 1; vcyc = 0; bad = 0;
    while (lat < 60) begin
      if (s_req_valid != 3'b000) begin
        vcyc++;
        if ({s_req_addr, s_req_we, s_req_wdata, s_req_be} !== {ea, ewe, ewd, ebe}) bad++;
      end
      if (m_rsp_valid != 2'b00) break;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drive_both(input int n);
    int acc = 0;
    int cyc = 0;
    @(negedge clk);
    m_req_valid = 2'b11;
    while (acc < n && cyc < 200) begin
      #1;
      if (m_req_ready != 2'b00) begin
        gnt_log.push_back(m_req_ready);
        acc++;
      end
      @(negedge clk);
      cyc++;
    end
    m_req_valid = 2'b00;
  endtask

  task automatic drain();
    int cyc = 0;
    while (sb.size() != 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int lat, vcyc, bad;
    rst = 1'b1;
    m_req_valid = 2'b11; m_req_we = '0; m_req_addr = '0; m_req_wdata = '0; m_req_be = '0;
    for (int i = 0; i < 3; i++) begin rdy_dly[i] = 0; mute[i] = 1'b0; end
    #1;
    chk("reset_m_req_ready", 32'(m_req_ready), 32'd0);
    chk("reset_m_rsp_valid", 32'(m_rsp_valid), 32'd0);
    chk("reset_s_req_valid", 32'(s_req_valid), 32'd0);
    chk("reset_rdata", m_rsp_rdata, 32'd0);
    chk("reset_err", 32'(m_rsp_err), 32'd0);
    m_req_valid = 2'b00;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Zero-wait ROM read from M1 (leaves the rr pointer at M0).
    sb.push_back('{m: 2'b10, rdata: 32'h0000_0013, err: 1'b0});
    do_req(1, 32'h0000_0010, 1'b0, 32'd0, 4'hF);
    wait_rsp(lat, vcyc, bad, 32'h0000_0010, 1'b0, 32'd0, 4'hF);
    chk("rom_read_latency", 32'(lat), 32'd3);
    chk("rom_read_req_cycles", 32'(vcyc), 32'd1);
    drain();

    // Both masters contending: grants must alternate starting at M0.
    m_req_addr = {32'h1000_0200, 32'h0000_0100};
    m_req_be = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{m: 2'b01, rdata: 32'h0000_0103, err: 1'b0});
      sb.push_back('{m: 2'b10, rdata: 32'h1000_0203, err: 1'b0});
    end
    gnt_log.delete();
    drive_both(4);
    chk("rr_grant_count", 32'(gnt_log.size()), 32'd4);
    for (int k = 0; k < gnt_log.size(); k++)
      chk($sformatf("rr_grant_%0d", k), 32'(gnt_log[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
    drain();

    // Unmapped address: error response, no slave request.
    sb.push_back('{m: 2'b01, rdata: 32'hDEAD_BEEF, err: 1'b1});
    do_req(0, 32'h5000_0000, 1'b0, 32'd0, 4'hF);
    chk("nohit_no_s_req", 32'(s_req_valid), 32'd0);
    wait_rsp(lat, vcyc, bad, 32'h5000_0000, 1'b0, 32'd0, 4'hF);
    chk("nohit_latency", 32'(lat), 32'd2);
    drain();

    // RAM write with a 5-cycle stalled slave: request fields must hold.
    rdy_dly[1] = 5;
    sb.push_back('{m: 2'b10, rdata: 32'h1000_0043, err: 1'b0});
    do_req(1, 32'h1000_0040, 1'b1, 32'hCAFE_F00D, 4'b0011);
    wait_rsp(lat, vcyc, bad, 32'h1000_0040, 1'b1, 32'hCAFE_F00D, 4'b0011);
    chk("wr_req_cycles", 32'(vcyc), 32'd6);
    chk("wr_fields_stable", 32'(bad), 32'd0);
    chk("wr_latency", 32'(lat), 32'd8);
    drain();
    rdy_dly[1] = 0;

    // Periph never ready: timeout after 8 cycles, then a clean ROM read.
    rdy_dly[2] = 1000;
    sb.push_back('{m: 2'b01, rdata: 32'hDEAD_BEEF, err: 1'b1});
    do_req(0, 32'h2000_0008, 1'b0, 32'd0, 4'hF);
    wait_rsp(lat, vcyc, bad, 32'h2000_0008, 1'b0, 32'd0, 4'hF);
    chk("tmo_req_cycles", 32'(vcyc), 32'd9);
    chk("tmo_latency", 32'(lat), 32'd11);
    chk("tmo_s_req_dropped", 32'(s_req_valid), 32'd0);
    drain();
    rdy_dly[2] = 0;
    sb.push_back('{m: 2'b01, rdata: 32'h0000_0033, err: 1'b0});
    do_req(0, 32'h0000_0030, 1'b0, 32'd0, 4'hF);
    wait_rsp(lat, vcyc, bad, 32'h0000_0030, 1'b0, 32'd0, 4'hF);
    chk("post_tmo_latency", 32'(lat), 32'd3);
    drain();

    // Reset while M0 waits in RSP; afterwards M0 must win first again.
    mute[0] = 1'b1;
    do_req(0, 32'h0000_0040, 1'b0, 32'd0, 4'hF);
    @(negedge clk);
    rst = 1'b1;
    m_req_valid = 2'b11;
    #1;
    chk("rst_mid_ready", 32'(m_req_ready), 32'd0);
    chk("rst_mid_rsp_valid", 32'(m_rsp_valid), 32'd0);
    chk("rst_mid_s_req_valid", 32'(s_req_valid), 32'd0);
    chk("rst_mid_s_req_addr", s_req_addr, 32'd0);
    chk("rst_mid_rdata", m_rsp_rdata, 32'd0);
    m_req_valid = 2'b00;
    mute[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_req_addr = {32'h1000_0200, 32'h0000_0020};
    sb.push_back('{m: 2'b01, rdata: 32'h0000_0023, err: 1'b0});
    sb.push_back('{m: 2'b10, rdata: 32'h1000_0203, err: 1'b0});
    gnt_log.delete();
    drive_both(2);
    chk("post_rst_grant_count", 32'(gnt_log.size()), 32'd2);
    if (gnt_log.size() > 0) chk("post_rst_first_grant", 32'(gnt_log[0]), 32'd1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
